// File: rtl/arbitro_sumador.sv
// Two-requester round-robin arbiter that sequences a 6-bit addition through a
// shared 3-bit ripple-carry adder in two passes, chaining the carry between them.
module arbitro_sumador #(
   parameter int unsigned PRIORITY_INIT = 0
) (
   input  logic       iClk,
   input  logic       iRst_n,
   input  logic       iReq0,
   input  logic       iReq1,
   input  logic [5:0] iA_0,
   input  logic [5:0] iB_0,
   input  logic [5:0] iA_1,
   input  logic [5:0] iB_1,
   output logic       oAck0,
   output logic       oAck1,
   output logic [6:0] oSum,
   output logic       oGrant,
   output logic       oBusy,
   output logic [2:0] oAddA,
   output logic [2:0] oAddB,
   output logic       oAddCin,
   input  logic [2:0] iAddS,
   input  logic       iAddCout
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StLow  = 2'd1;
   localparam logic [1:0] StHigh = 2'd2;
   localparam logic [1:0] StDone = 2'd3;

   logic [1:0] state_q, state_d;
   logic       prio_q, prio_d;
   logic       grant_q, grant_d;
   logic [5:0] a_q, a_d;
   logic [5:0] b_q, b_d;
   logic [2:0] lo_q, lo_d;    // low-pass sum, kept apart so oSum holds until completion
   logic       c_q, c_d;      // carry from the low pass into the high pass
   logic [6:0] sum_q, sum_d;
   logic       sel;

   // Next-state: arbitration in idle, then low pass, high pass, acknowledge.
   always_comb begin
      state_d = state_q;
      prio_d  = prio_q;
      grant_d = grant_q;
      a_d     = a_q;
      b_d     = b_q;
      lo_d    = lo_q;
      c_d     = c_q;
      sum_d   = sum_q;
      sel     = 1'b0;
      case (state_q)
         StIdle: begin
            if (iReq0 || iReq1) begin
               // A lone requester wins outright; a tie goes to the favoured one.
               sel     = (iReq0 && iReq1) ? prio_q : iReq1;
               grant_d = sel;
               a_d     = sel ? iA_1 : iA_0;
               b_d     = sel ? iB_1 : iB_0;
               state_d = StLow;
            end
         end
         StLow: begin
            lo_d    = iAddS;
            c_d     = iAddCout;
            state_d = StHigh;
         end
         StHigh: begin
            sum_d   = {iAddCout, iAddS, lo_q};
            state_d = StDone;
         end
         StDone: begin
            prio_d  = ~grant_q;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         state_q <= StIdle;
         prio_q  <= 1'(PRIORITY_INIT);
         grant_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         lo_q    <= '0;
         c_q     <= 1'b0;
         sum_q   <= '0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         grant_q <= grant_d;
         a_q     <= a_d;
         b_q     <= b_d;
         lo_q    <= lo_d;
         c_q     <= c_d;
         sum_q   <= sum_d;
      end
   end

   // Adder drive and status outputs, decoded from the current state.
   always_comb begin
      oAddA   = 3'b000;
      oAddB   = 3'b000;
      oAddCin = 1'b0;
      case (state_q)
         StLow: begin
            oAddA = a_q[2:0];
            oAddB = b_q[2:0];
         end
         StHigh: begin
            oAddA   = a_q[5:3];
            oAddB   = b_q[5:3];
            oAddCin = c_q;
         end
         default: ;
      endcase
      oAck0  = (state_q == StDone) && !grant_q;
      oAck1  = (state_q == StDone) && grant_q;
      oBusy  = (state_q != StIdle);
      oGrant = grant_q;
      oSum   = sum_q;
   end

endmodule

// File: tb/tb_arbitro_sumador.sv
// Self-checking bench: two instances (PRIORITY_INIT 0 and 1) share the stimulus,
// each checked every cycle against a transaction-level model, plus literal checks.
module tb_arbitro_sumador;

   logic       clk;
   logic       rst_n;
   logic       req0, req1;
   logic [5:0] a0, b0, a1, b1;

   logic       ack0_w  [2];
   logic       ack1_w  [2];
   logic [6:0] sum_w   [2];
   logic       grant_w [2];
   logic       busy_w  [2];
   logic [2:0] adda_w  [2];
   logic [2:0] addb_w  [2];
   logic       cin_w   [2];
   logic [2:0] s_w     [2];
   logic       cout_w  [2];

   int n_chk  = 0;
   int n_pass = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar k = 0; k < 2; k++) begin : g_dut
      // Shared ripple-carry adder seen by this instance.
      assign {cout_w[k], s_w[k]} = {1'b0, adda_w[k]} + {1'b0, addb_w[k]} + {3'b000, cin_w[k]};

      arbitro_sumador #(.PRIORITY_INIT(k)) u_dut (
         .iClk     (clk),
         .iRst_n   (rst_n),
         .iReq0    (req0),
         .iReq1    (req1),
         .iA_0     (a0),
         .iB_0     (b0),
         .iA_1     (a1),
         .iB_1     (b1),
         .oAck0    (ack0_w[k]),
         .oAck1    (ack1_w[k]),
         .oSum     (sum_w[k]),
         .oGrant   (grant_w[k]),
         .oBusy    (busy_w[k]),
         .oAddA    (adda_w[k]),
         .oAddB    (addb_w[k]),
         .oAddCin  (cin_w[k]),
         .iAddS    (s_w[k]),
         .iAddCout (cout_w[k])
      );
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      else n_pass++;
   endtask

   // Model: per instance, whether a job is active, cycles since its grant,
   // who is served, the latched operands, the last result and the favoured requester.
   bit m_valid = 1'b0;
   bit m_act  [2];
   int m_age  [2];
   bit m_gnt  [2];
   bit m_prio [2];
   int m_a    [2];
   int m_b    [2];
   int m_sum  [2];

   function automatic bit pick(input bit r0, input bit r1, input bit p);
      return (r0 && r1) ? p : r1;
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            m_act[k]  <= 1'b0;
            m_age[k]  <= 0;
            m_gnt[k]  <= 1'b0;
            m_prio[k] <= 1'(k);
            m_a[k]    <= 0;
            m_b[k]    <= 0;
            m_sum[k]  <= 0;
         end else if (!m_act[k]) begin
            if (req0 || req1) begin
               m_gnt[k] <= pick(req0, req1, m_prio[k]);
               m_a[k]   <= pick(req0, req1, m_prio[k]) ? int'(a1) : int'(a0);
               m_b[k]   <= pick(req0, req1, m_prio[k]) ? int'(b1) : int'(b0);
               m_act[k] <= 1'b1;
               m_age[k] <= 1;
            end
         end else if (m_age[k] == 3) begin
            m_act[k]  <= 1'b0;
            m_age[k]  <= 0;
            m_prio[k] <= !m_gnt[k];
         end else begin
            m_age[k] <= m_age[k] + 1;
            if (m_age[k] == 2) m_sum[k] <= m_a[k] + m_b[k];
         end
      end
      if (!rst_n) m_valid <= 1'b1;
   end

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (m_valid) begin
         for (int k = 0; k < 2; k++) begin
            int ea, eb, ec, done;
            ea = 0; eb = 0; ec = 0;
            done = (m_act[k] && m_age[k] == 3) ? 1 : 0;
            if (m_act[k] && m_age[k] == 1) begin
               ea = m_a[k] % 8;
               eb = m_b[k] % 8;
            end else if (m_act[k] && m_age[k] == 2) begin
               ea = m_a[k] / 8;
               eb = m_b[k] / 8;
               ec = ((m_a[k] % 8) + (m_b[k] % 8) >= 8) ? 1 : 0;
            end
            chk("model_busy",  32'(busy_w[k]),  32'(m_act[k]));
            chk("model_ack0",  32'(ack0_w[k]),  32'(done != 0 && !m_gnt[k]));
            chk("model_ack1",  32'(ack1_w[k]),  32'(done != 0 && m_gnt[k]));
            chk("model_grant", 32'(grant_w[k]), 32'(m_gnt[k]));
            chk("model_sum",   32'(sum_w[k]),   32'(m_sum[k]));
            chk("model_adda",  32'(adda_w[k]),  32'(ea));
            chk("model_addb",  32'(addb_w[k]),  32'(eb));
            chk("model_cin",   32'(cin_w[k]),   32'(ec));
         end
      end
   end

   // One isolated request; new_a is applied one cycle after the grant.
   task automatic run_op(input bit who, input int a, input int b, input int new_a,
                         input int exp_sum, input int exp_cin);
      bit got;
      @(negedge clk);
      if (who) begin req1 = 1'b1; a1 = 6'(a); b1 = 6'(b); end
      else     begin req0 = 1'b1; a0 = 6'(a); b0 = 6'(b); end
      got = 1'b0;
      for (int c = 1; c <= 8 && !got; c++) begin
         @(negedge clk);
         if (c == 1) begin
            if (who) a1 = 6'(new_a);
            else     a0 = 6'(new_a);
         end
         if (c == 2) chk("high_pass_cin", 32'(cin_w[0]), 32'(exp_cin));
         if (ack0_w[0] || ack1_w[0]) begin
            got = 1'b1;
            chk("ack_latency", 32'(c), 32'd3);
            chk("result_sum", 32'(sum_w[0]), 32'(exp_sum));
            chk("result_grant", 32'(grant_w[0]), 32'(who));
            chk("other_ack_low", 32'(who ? ack0_w[0] : ack1_w[0]), 32'd0);
         end
      end
      if (!got) chk("ack_timeout", 32'd0, 32'd1);
      req0 = 1'b0;
      req1 = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_busy", 32'(busy_w[0]), 32'd0);
      chk("reset_sum", 32'(sum_w[0]), 32'd0);
      chk("reset_grant", 32'(grant_w[0]), 32'd0);
      rst_n = 1'b1;
   endtask

   initial begin
      int last, n;
      bit got;
      rst_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      repeat (2) @(negedge clk);
      chk("reset_busy", 32'(busy_w[0]), 32'd0);
      chk("reset_sum", 32'(sum_w[0]), 32'd0);
      chk("reset_ack", 32'(ack0_w[0] | ack1_w[0]), 32'd0);
      chk("reset_adda", 32'(adda_w[0]), 32'd0);
      rst_n = 1'b1;

      run_op(1'b0, 45, 30, 45, 75, 1);
      run_op(1'b1, 7, 1, 7, 8, 1);
      run_op(1'b0, 63, 63, 63, 126, 1);
      run_op(1'b0, 0, 0, 0, 0, 0);
      run_op(1'b0, 12, 3, 50, 15, 0);

      // Tie arbitration from a fresh priority state.
      do_reset();
      @(negedge clk);
      req0 = 1'b1; a0 = 6'd10; b0 = 6'd5;
      req1 = 1'b1; a1 = 6'd20; b1 = 6'd22;
      last = -1;
      n = 0;
      for (int c = 1; c <= 24 && n < 4; c++) begin
         @(negedge clk);
         if (ack0_w[0] || ack1_w[0]) begin
            chk("tie_order", 32'(ack1_w[0]), 32'(n % 2));
            chk("tie_sum", 32'(sum_w[0]), (n % 2 != 0) ? 32'd42 : 32'd15);
            if (last < 0) begin
               chk("tie_first_latency", 32'(c), 32'd3);
               chk("prio1_first_grant", 32'(ack1_w[1]), 32'd1);
               chk("prio1_first_sum", 32'(sum_w[1]), 32'd42);
            end else begin
               chk("tie_spacing", 32'(c - last), 32'd4);
            end
            last = c;
            n++;
         end
      end
      chk("tie_ack_count", 32'(n), 32'd4);
      req0 = 1'b0;
      req1 = 1'b0;

      // Reset during the high pass, request held through it.
      @(negedge clk);
      req0 = 1'b1; a0 = 6'd20; b0 = 6'd9;
      @(negedge clk);
      @(negedge clk);
      chk("pre_reset_busy", 32'(busy_w[0]), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_busy", 32'(busy_w[0]), 32'd0);
      chk("midrst_sum", 32'(sum_w[0]), 32'd0);
      chk("midrst_no_ack", 32'(ack0_w[0] | ack1_w[0]), 32'd0);
      rst_n = 1'b1;
      got = 1'b0;
      for (int c = 1; c <= 8 && !got; c++) begin
         @(negedge clk);
         if (ack0_w[0]) begin
            got = 1'b1;
            chk("restart_latency", 32'(c), 32'd3);
            chk("restart_sum", 32'(sum_w[0]), 32'd29);
         end
      end
      if (!got) chk("restart_timeout", 32'd0, 32'd1);
      req0 = 1'b0;

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/arbitro_sumador.md
# arbitro_sumador

Two-requester arbiter and sequencer for the shared 3-bit ripple-carry adder. Each requester presents a 6-bit addition. The block grants one requester at a time, round-robin, and splits the operation into two 3-bit passes through the adder, chaining the carry between passes. It returns a 7-bit result with a one-cycle acknowledge. It sits between the requesting units and the single adder instance, and is the only driver of the adder's inputs.

## Interface
- PRIORITY_INIT, default 0: requester favoured on a tie after reset (0 or 1).
- iClk  in  1  clock; all state changes on the rising edge.
- iRst_n  in  1  reset; synchronous, active-low.
- iReq0, iReq1  in  1  level request, held until the matching ack.
- iA_0, iB_0  in  6  requester 0 operands.
- iA_1, iB_1  in  6  requester 1 operands.
- oAck0, oAck1  out  1  one-cycle pulse: result for that requester is valid.
- oSum  out  7  result {carry, sum[5:0]}; holds until the next completion.
- oGrant  out  1  index of the requester currently being served.
- oBusy  out  1  high while an operation is in progress (LOW, HIGH, DONE).
- oAddA, oAddB  out  3  adder operand drive.
- oAddCin  out  1  adder carry-in drive.
- iAddS  in  3  adder sum, combinational from oAdd*.
- iAddCout  in  1  adder carry-out.

## Operation
- FSM states: IDLE, LOW, HIGH, DONE. A 1-bit register prio holds round-robin priority.
- **IDLE**
  - With no request, stay in IDLE.
  - With exactly one request, grant that requester.
  - With both requesting, grant prio.
  - On grant: latch that requester's operands into internal 6-bit registers, set oGrant, go to LOW.
- **LOW**
  - Drive oAddA=A[2:0], oAddB=B[2:0], oAddCin=0.
  - At the edge: sum[2:0] <= iAddS, cReg <= iAddCout. Go to HIGH.
- **HIGH**
  - Drive oAddA=A[5:3], oAddB=B[5:3], oAddCin=cReg.
  - At the edge: sum[5:3] <= iAddS, sum[6] <= iAddCout. Go to DONE.
- **DONE**
  - oSum presents the new result.
  - oAck(oGrant) = 1 for this cycle only.
  - prio <= ~oGrant. Go to IDLE.
- oAddA, oAddB and oAddCin are 0 in IDLE and DONE.
- Result is the full unsigned sum: oSum = A + B, 0..126, no truncation.
- Operands are latched at grant. Operand changes after the grant are ignored.
- Request deasserted mid-operation: the operation still completes and the ack is still issued.
- A requester still asserting req during its ack cycle is treated as a new request at the following IDLE cycle.
- Both requesters asserting continuously: grants strictly alternate.
- Reset values:
  - state=IDLE, prio=PRIORITY_INIT.
  - oSum=0, oAck0=oAck1=0, oGrant=0, oBusy=0.
  - oAdd*=0, cReg=0, operand registers=0.

## Timing
- Request seen high at edge T, with state IDLE, is granted at edge T.
- From grant: LOW during cycle T+1, HIGH during T+2, DONE during T+3. oAck and the new oSum are visible in cycle T+3.
- Request-to-ack latency is 3 cycles. Throughput is one operation per 4 cycles: the next grant occurs at the end of the IDLE cycle T+4.
- The adder path is combinational within each cycle. oAdd* must settle and iAdd* must be sampled in the same cycle.
- Reset asserted in any state takes effect at the next edge:
  - In-flight operation aborted, no ack issued.
  - All outputs return to reset values; oSum clears to 0.
- A request arriving during LOW/HIGH/DONE waits and is arbitrated in the next IDLE cycle.

## Test plan
- Single request: iReq0=1, iA_0=45, iB_0=30, one cycle after reset release → oAck0 pulse exactly 3 cycles after grant, oSum=75, oGrant=0, oAck1 stays 0.
- Inter-pass carry: iReq1=1, iA_1=7, iB_1=1 → low pass gives 0 with cReg=1; final oSum=8, oAck1 pulses.
- Maximum overflow: A=63, B=63 on requester 0 → oSum=126 (bit 6 set). Then A=0, B=0 → oSum=0.
- Tie arbitration with PRIORITY_INIT=0, both requests held with distinct operands (req0: 10+5, req1: 20+22):
  - Acks arrive in order 0, 1, 0, 1… with 4-cycle spacing.
  - oSum alternates 15 and 42.
  - With PRIORITY_INIT=1, requester 1 is served first.
- Operand stability: change iA_0 from 12 to 50 one cycle after the grant (A=12, B=3) → oSum=15.
- Reset mid-operation: assert iRst_n=0 while in HIGH → next cycle oBusy=0, oSum=0, no ack pulse. After release with the request still held, the operation restarts and completes normally.
